// File: rtl/wait_state_memory_pkg.sv
// Shared encodings and helpers for the wait-state memory and its load path.
package mem_pkg;

  localparam int unsigned SIZE_W  = 2;
  localparam int unsigned STATE_W = 2;

  // Access size encodings
  localparam logic [SIZE_W-1:0] SZ_BYTE = 2'b00;
  localparam logic [SIZE_W-1:0] SZ_HALF = 2'b01;
  localparam logic [SIZE_W-1:0] SZ_WORD = 2'b10;
  localparam logic [SIZE_W-1:0] SZ_ILL  = 2'b11;

  // FSM state encodings
  localparam logic [STATE_W-1:0] S_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] S_WAIT = 2'd1;
  localparam logic [STATE_W-1:0] S_RESP = 2'd2;

  // Natural-alignment check for half and word accesses
  function automatic logic is_misaligned(input logic [SIZE_W-1:0] size, input logic [1:0] lo);
    case (size)
      SZ_HALF: return lo[0];
      SZ_WORD: return lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  // Number of byte lanes touched by an access
  function automatic logic [2:0] size_bytes(input logic [SIZE_W-1:0] size);
    case (size)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/wait_state_memory_load_extend.sv
// Sign/zero extension of raw little-endian lane data for lb/lh/lw/lbu/lhu.
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0]       raw,
  input  logic [SIZE_W-1:0] size,
  input  logic              is_unsigned,
  output logic [31:0]       ext_c
);

  // Pick the low lanes and extend to 32 bits
  always_comb begin
    ext_c = raw;
    case (size)
      SZ_BYTE: ext_c = is_unsigned ? {24'd0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
      SZ_HALF: ext_c = is_unsigned ? {16'd0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: ext_c = raw;
    endcase
  end

endmodule

// File: rtl/wait_state_memory.sv
// Byte-addressed little-endian memory with valid/ready handshake and wait states.
module wait_state_memory
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned LATENCY     = 2,
  parameter bit          ALIGN_CHECK = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [SIZE_W-1:0] req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              busy
);

  localparam int unsigned        DEPTH    = 2 ** ADDR_W;
  localparam int unsigned        CNT_W    = 4;
  localparam bit                 ZERO_LAT = (LATENCY == 0);
  localparam logic [CNT_W-1:0]   CNT_LOAD = ZERO_LAT ? '0 : CNT_W'(LATENCY - 1);
  localparam logic [32:0]        DEPTH_X  = 33'(1) << ADDR_W;

  logic [7:0] mem [DEPTH];

  logic [STATE_W-1:0] state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;

  // Latched request
  logic              we_q, we_n;
  logic [SIZE_W-1:0] size_q, size_n;
  logic              uns_q, uns_n;
  logic [ADDR_W-1:0] idx_q, idx_n;
  logic [31:0]       wdata_q, wdata_n;

  // Result held between commit and response
  logic [31:0] res_rdata_q, res_rdata_n;
  logic        res_err_q, res_err_n;

  logic        resp_valid_n, resp_err_n, req_ready_n;
  logic [31:0] resp_rdata_n;

  // Access currently being committed: live inputs in IDLE, latched copy otherwise
  logic              cur_we_c;
  logic [SIZE_W-1:0] cur_size_c;
  logic              cur_uns_c;
  logic [ADDR_W-1:0] cur_idx_c;
  logic [31:0]       cur_wdata_c;

  logic [32:0]       last_c;
  logic              in_err_c;
  logic              commit_c;
  logic [ADDR_W-1:0] lane_idx_c [4];
  logic [31:0]       raw_c;
  logic [31:0]       ext_c;

  // Select the access source
  always_comb begin
    if (state == S_IDLE) begin
      cur_we_c    = req_we;
      cur_size_c  = req_size;
      cur_uns_c   = req_unsigned;
      cur_idx_c   = req_addr[ADDR_W-1:0];
      cur_wdata_c = req_wdata;
    end else begin
      cur_we_c    = we_q;
      cur_size_c  = size_q;
      cur_uns_c   = uns_q;
      cur_idx_c   = idx_q;
      cur_wdata_c = wdata_q;
    end
  end

  // Request error: illegal size, any lane past the top, or misaligned when checked
  always_comb begin
    last_c   = {1'b0, req_addr} + 33'(size_bytes(req_size)) - 33'd1;
    in_err_c = (req_size == SZ_ILL) || (last_c >= DEPTH_X) ||
               (ALIGN_CHECK && is_misaligned(req_size, req_addr[1:0]));
  end

  // Gather the four byte lanes starting at the access address
  always_comb begin
    raw_c = '0;
    for (int k = 0; k < 4; k++) begin
      lane_idx_c[k]    = cur_idx_c + ADDR_W'(k);
      raw_c[8*k +: 8]  = mem[lane_idx_c[k]];
    end
  end

  load_extend u_load_extend (
    .raw         (raw_c),
    .size        (cur_size_c),
    .is_unsigned (cur_uns_c),
    .ext_c       (ext_c)
  );

  // Commit edge: zero-latency accept in IDLE, or counter expiry in WAIT
  assign commit_c = !reset &&
                    ((state == S_IDLE && req_valid && !in_err_c && ZERO_LAT) ||
                     (state == S_WAIT && cnt == '0));

  // Byte-lane writes; the array is deliberately not reset
  always_ff @(posedge clk) begin
    if (commit_c && cur_we_c) begin
      for (int k = 0; k < 4; k++) begin
        if (3'(k) < size_bytes(cur_size_c)) mem[lane_idx_c[k]] <= cur_wdata_c[8*k +: 8];
      end
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    we_n         = we_q;
    size_n       = size_q;
    uns_n        = uns_q;
    idx_n        = idx_q;
    wdata_n      = wdata_q;
    res_rdata_n  = res_rdata_q;
    res_err_n    = res_err_q;
    resp_valid_n = 1'b0;
    resp_rdata_n = resp_rdata;
    resp_err_n   = resp_err;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          we_n    = req_we;
          size_n  = req_size;
          uns_n   = req_unsigned;
          idx_n   = req_addr[ADDR_W-1:0];
          wdata_n = req_wdata;
          if (in_err_c) begin
            res_err_n   = 1'b1;
            res_rdata_n = '0;
            state_n     = S_RESP;
          end else if (ZERO_LAT) begin
            res_err_n   = 1'b0;
            res_rdata_n = req_we ? 32'd0 : ext_c;
            state_n     = S_RESP;
          end else begin
            cnt_n   = CNT_LOAD;
            state_n = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt == '0) begin
          res_err_n   = 1'b0;
          res_rdata_n = we_q ? 32'd0 : ext_c;
          state_n     = S_RESP;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      S_RESP: begin
        resp_valid_n = 1'b1;
        resp_rdata_n = res_rdata_q;
        resp_err_n   = res_err_q;
        state_n      = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    req_ready_n = (state_n == S_IDLE);
  end

  // State, counter, request latch and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      we_q        <= 1'b0;
      size_q      <= SZ_BYTE;
      uns_q       <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= '0;
      res_rdata_q <= '0;
      res_err_q   <= 1'b0;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
      resp_err    <= 1'b0;
      req_ready   <= 1'b1;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      we_q        <= we_n;
      size_q      <= size_n;
      uns_q       <= uns_n;
      idx_q       <= idx_n;
      wdata_q     <= wdata_n;
      res_rdata_q <= res_rdata_n;
      res_err_q   <= res_err_n;
      resp_valid  <= resp_valid_n;
      resp_rdata  <= resp_rdata_n;
      resp_err    <= resp_err_n;
      req_ready   <= req_ready_n;
    end
  end

  assign busy = ~req_ready;

endmodule

// File: tb/tb_wait_state_memory.sv
// Directed self-checking bench: LATENCY=2 instance for access/error/reset cases,
// LATENCY=0 instance for back-to-back traffic with req_valid held high.
module tb_wait_state_memory;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // LATENCY=2 instance
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata, resp_rdata;
  logic        resp_valid, resp_err, busy;

  wait_state_memory #(.ADDR_W(8), .LATENCY(2), .ALIGN_CHECK(1'b1)) dut (
    .clk (clk), .reset (reset),
    .req_valid (req_valid), .req_ready (req_ready), .req_we (req_we),
    .req_size (req_size), .req_unsigned (req_unsigned), .req_addr (req_addr),
    .req_wdata (req_wdata), .resp_valid (resp_valid), .resp_rdata (resp_rdata),
    .resp_err (resp_err), .busy (busy)
  );

  // LATENCY=0 instance
  logic        b_valid, b_ready, b_we, b_unsigned;
  logic [1:0]  b_size;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic        b_resp_valid, b_err, b_busy;

  wait_state_memory #(.ADDR_W(8), .LATENCY(0), .ALIGN_CHECK(1'b1)) dut0 (
    .clk (clk), .reset (reset),
    .req_valid (b_valid), .req_ready (b_ready), .req_we (b_we),
    .req_size (b_size), .req_unsigned (b_unsigned), .req_addr (b_addr),
    .req_wdata (b_wdata), .resp_valid (b_resp_valid), .resp_rdata (b_rdata),
    .resp_err (b_err), .busy (b_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // One request on the LATENCY=2 instance; lat = edges from handshake to resp_valid, -1 on timeout
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat);
    int t0;
    int n;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1;
    t0 = cyc;
    req_valid = 1'b0;
    lat = -1; rdata = 'x; err = 1'bx;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = cyc - t0; rdata = resp_rdata; err = resp_err;
        break;
      end
    end
    @(negedge clk);
    chk("resp_pulse_width", 32'(resp_valid), 32'd0);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;

  // Back-to-back stream for the LATENCY=0 instance: 4 stores then 4 loads
  logic [31:0] s_addr [8];
  logic [31:0] s_wd   [8];
  logic        s_we   [8];
  logic [31:0] s_exp  [8];
  int          acc_cyc [8];

  initial begin
    reset = 1'b1;
    req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0; req_addr = 0; req_wdata = 0;
    b_valid = 0; b_we = 0; b_size = 0; b_unsigned = 0; b_addr = 0; b_wdata = 0;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Word store/load and latency
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lat);
    chk("sw_lat", 32'(lat), 32'd3);
    chk("sw_err", 32'(er), 32'd0);
    chk("sw_rdata", rd, 32'd0);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat);
    chk("lw_lat", 32'(lat), 32'd3);
    chk("lw_10", rd, 32'hDEADBEEF);

    // Sub-word loads
    do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, rd, er, lat);
    chk("lb_13", rd, 32'hFFFFFFDE);
    do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, rd, er, lat);
    chk("lbu_13", rd, 32'h000000DE);
    do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, rd, er, lat);
    chk("lh_12", rd, 32'hFFFFDEAD);
    do_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, rd, er, lat);
    chk("lhu_12", rd, 32'h0000DEAD);

    // Sub-word stores
    do_req(1'b1, 2'b00, 1'b0, 32'h11, 32'hAAAAAA55, rd, er, lat);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat);
    chk("lw_after_sb", rd, 32'hDEAD55EF);
    do_req(1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFF1234, rd, er, lat);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat);
    chk("lw_after_sh", rd, 32'h123455EF);

    // Errors
    do_req(1'b0, 2'b10, 1'b0, 32'h12, 32'h0, rd, er, lat);
    chk("mis_lat", 32'(lat), 32'd1);
    chk("mis_err", 32'(er), 32'd1);
    chk("mis_rdata", rd, 32'd0);
    do_req(1'b1, 2'b10, 1'b0, 32'h100, 32'hCAFEF00D, rd, er, lat);
    chk("oor_err", 32'(er), 32'd1);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat);
    chk("lw_after_oor", rd, 32'h123455EF);
    do_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, rd, er, lat);
    chk("ill_err", 32'(er), 32'd1);
    chk("ill_rdata", rd, 32'd0);

    // Reset during WAIT aborts the store
    do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, rd, er, lat);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h20; req_wdata = 32'h0BADF00D;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("wait_busy", 32'(busy), 32'd1);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("async_rst_ready", 32'(req_ready), 32'd1);
    chk("async_rst_valid", 32'(resp_valid), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("no_resp_after_rst", 32'(resp_valid), 32'd0);
    end
    do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, er, lat);
    chk("lw_20_kept", rd, 32'h11223344);

    // LATENCY=0 back-to-back with req_valid held high
    for (int i = 0; i < 8; i++) begin
      s_we[i]   = (i < 4);
      s_addr[i] = 32'h40 + 32'(4 * (i % 4));
      s_wd[i]   = 32'hA0000000 + 32'(i * 16'h1111);
    end
    s_exp[0] = 0; s_exp[1] = 0; s_exp[2] = 0; s_exp[3] = 0;
    s_exp[4] = 32'hA0000000; s_exp[5] = 32'hA0001111;
    s_exp[6] = 32'hA0002222; s_exp[7] = 32'hA0003333;
    begin
      int i;
      int r;
      i = 0;
      r = 0;
      for (int t = 0; t < 60 && r < 8; t++) begin
        @(negedge clk);
        if (b_resp_valid) begin
          if (r < 8) begin
            chk("b2b_rdata", b_rdata, s_exp[r]);
            chk("b2b_err", 32'(b_err), 32'd0);
            chk("b2b_lat", 32'(cyc - acc_cyc[r]), 32'd1);
          end
          r++;
        end
        if (i < 8) begin
          b_valid = 1'b1; b_we = s_we[i]; b_size = 2'b10; b_unsigned = 1'b0;
          b_addr = s_addr[i]; b_wdata = s_wd[i];
          if (b_ready) begin
            acc_cyc[i] = cyc + 1;
            i++;
          end
        end else begin
          b_valid = 1'b0;
        end
      end
      b_valid = 1'b0;
      chk("b2b_accepted", 32'(i), 32'd8);
      chk("b2b_responses", 32'(r), 32'd8);
      chk("b2b_rate", 32'(acc_cyc[7] - acc_cyc[0]), 32'd14);
      repeat (3) begin
        @(negedge clk);
        chk("b2b_no_extra_resp", 32'(b_resp_valid), 32'd0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
